// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared state, size and byte-enable definitions for mem_access_unit
package mau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mau_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE    = 4'b0001;

    function automatic logic [3:0] be_decode(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: be_decode = BE_BYTE << addr_lo;
            SZ_HALF: be_decode = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be_decode = BE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

    // Low address bits with the sub-size offset forced to natural alignment.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: align_lo = addr_lo;
            SZ_HALF: align_lo = {addr_lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory signals of mem_access_unit
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, dm_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_be, dm_din
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, dm_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_be, dm_din
    );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a memory word and extends it to 32 bits
module load_align
    import mau_pkg::*;
(
    input  logic [31:0] i_dm_dout,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_dm_dout[7:0];
            2'd1:    w_byte = i_dm_dout[15:8];
            2'd2:    w_byte = i_dm_dout[23:16];
            default: w_byte = i_dm_dout[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_dm_dout[31:16] : i_dm_dout[15:0];
    end

    always_comb begin
        o_data = i_dm_dout;
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_dm_dout;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit, 3-cycle IDLE/ACCESS/RESP sequence; MEM_ACCESS_MISALIGN_TRAP_EN enables misalignment trapping
module mem_access_unit
    import mau_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);

    mau_state_e  r_state;
    logic [11:0] r_addr;
    logic [1:0]  r_size;
    logic        r_wr;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [1:0]  w_size;
    logic [11:0] w_addr;
    logic [31:0] w_load_data;
    logic        w_unused;

    assign w_unused = ^bus.req_addr[31:12];

    // Reserved size behaves exactly like a word from acceptance onwards.
    assign w_size = (bus.req_size == SZ_RSVD) ? SZ_WORD : bus.req_size;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = is_misaligned(w_size, bus.req_addr[1:0]);
    assign w_addr       = bus.req_addr[11:0];
`else
    assign w_addr = {bus.req_addr[11:2], align_lo(w_size, bus.req_addr[1:0])};
`endif

    load_align u_load_align (
        .i_dm_dout  (bus.dm_dout),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_size       <= SZ_BYTE;
            r_wr         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr     <= w_addr;
                        r_size     <= w_size;
                        r_wr       <= bus.req_wr;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata;
                        r_state    <= ST_ACCESS;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                        end
`endif
                    end
                end
                ST_ACCESS: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_wr ? 32'h0 : w_load_data;
                    r_resp_err   <= 1'b0;
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // dm_we decodes straight from state so an async reset drops it at once.
    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.dm_we      = (r_state == ST_ACCESS) && r_wr;
    assign bus.dm_be      = (r_state == ST_ACCESS) ? be_decode(r_size, r_addr[1:0]) : BE_NONE;
    assign bus.dm_addr    = r_addr[11:2];
    assign bus.dm_din     = r_wdata;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit against a byte-array model
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem       [0:1023];
    logic [7:0]  ref_bytes [0:4095];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_cnt   = 0;
    int          be_cnt   = 0;
    logic [3:0]  last_be  = 4'h0;

    assign bus.dm_dout = mem[bus.dm_addr];

    // Memory places right-justified store data into the enabled lanes, writing on the falling edge.
    always @(negedge clk) begin
        int sh;
        logic [31:0] wd;
        if (bus.dm_we) begin
            we_cnt++;
            sh = 0;
            for (int k = 3; k >= 0; k--) if (bus.dm_be[k]) sh = k;
            wd = bus.dm_din << (8 * sh);
            for (int k = 0; k < 4; k++) if (bus.dm_be[k]) mem[bus.dm_addr][8*k +: 8] = wd[8*k +: 8];
        end
        if (bus.dm_be != 4'h0) begin
            be_cnt++;
            last_be = bus.dm_be;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input bit wr, input logic [1:0] size, input bit uns, input logic [11:0] addr_in,
                         input logic [31:0] wdata, output bit err, output logic [31:0] rdata,
                         output logic [3:0] be);
        int n;
        int a;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a = int'(addr_in);
        err = 1'b0;
        rdata = 32'h0;
        be = 4'h0;
        if (a % n != 0) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            err = 1'b1;
            return;
`else
            a = a - (a % n);
`endif
        end
        be = 4'(((1 << n) - 1) << (a % 4));
        for (int i = 0; i < n; i++) begin
            if (wr) ref_bytes[a + i] = wdata[8*i +: 8];
            else    rdata[8*i +: 8] = ref_bytes[a + i];
        end
        if (!wr && !uns && n < 4 && rdata[8*n - 1])
            for (int i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
    endtask

    task automatic do_req(input bit wr, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        bit          exp_err;
        logic [3:0]  exp_be;
        int          lat;
        int          we0;
        int          be0;
        bit          found;
        model(wr, size, uns, addr[11:0], wdata, exp_err, exp_rdata, exp_be);
        @(negedge clk);
        check_eq("ready_idle", bus.req_ready, 1'b1);
        bus.req_wr = wr;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        we0 = we_cnt;
        be0 = be_cnt;
        @(posedge clk);
        #1;
        // Request fields change while busy; the unit must work from its registered copy.
        bus.req_wr = 1'($urandom);
        bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        found = 1'b0;
        got_rdata = 32'h0;
        got_err = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin
                found = 1'b1;
                got_rdata = bus.resp_rdata;
                got_err = bus.resp_err;
                bus.req_valid = 1'b0;
            end else begin
                check_eq("ready_busy", bus.req_ready, 1'b0);
            end
        end
        bus.req_valid = 1'b0;
        check_eq("latency", lat, exp_err ? 1 : 2);
        check_eq("resp_rdata", got_rdata, exp_rdata);
        check_eq("resp_err", got_err, exp_err);
        @(negedge clk);
        check_eq("resp_pulse", bus.resp_valid, 1'b0);
        check_eq("ready_after", bus.req_ready, 1'b1);
        check_eq("we_cycles", we_cnt - we0, (wr && !exp_err) ? 1 : 0);
        check_eq("be_cycles", be_cnt - be0, exp_err ? 0 : 1);
        if (!exp_err) check_eq("dm_be", last_be, exp_be);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] w;
        logic [1:0]  sz;

        for (int wi = 0; wi < 1024; wi++) mem[wi] = $urandom;
        mem[0] = 32'h8899AABB;
        for (int wi = 0; wi < 1024; wi++)
            for (int b = 0; b < 4; b++) ref_bytes[4*wi + b] = mem[wi][8*b +: 8];

        bus.req_valid = 1'b0;
        bus.req_wr = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;

        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_ready", bus.req_ready, 1'b1);
        check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
        check_eq("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check_eq("rst_resp_err", bus.resp_err, 1'b0);
        check_eq("rst_dm_we", bus.dm_we, 1'b0);
        check_eq("rst_dm_be", bus.dm_be, 4'h0);
        check_eq("rst_dm_addr", bus.dm_addr, 10'h0);
        check_eq("rst_dm_din", bus.dm_din, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 2'b00, 1'b0, 32'h003, 32'h0, r, e);
        check_eq("ld_b_s_003", r, 32'hFFFFFF88);
        do_req(1'b0, 2'b01, 1'b1, 32'h002, 32'h0, r, e);
        check_eq("ld_h_u_002", r, 32'h00008899);
        do_req(1'b0, 2'b00, 1'b0, 32'h000, 32'h0, r, e);
        check_eq("ld_b_s_000", r, 32'hFFFFFFBB);

        do_req(1'b1, 2'b00, 1'b0, 32'h011, 32'h0000005A, r, e);
        check_eq("st_b_be", last_be, 4'b0010);
        check_eq("st_b_rdata", r, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, r, e);
        check_eq("ld_w_010_b1", r[15:8], 8'h5A);

        w = {ref_bytes[7], ref_bytes[6], ref_bytes[5], ref_bytes[4]};
        do_req(1'b0, 2'b10, 1'b0, 32'h006, 32'h0, r, e);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check_eq("misal_err", e, 1'b1);
        check_eq("misal_rdata", r, 32'h0);
`else
        check_eq("misal_err", e, 1'b0);
        check_eq("misal_rdata", r, w);
`endif

        @(negedge clk);
        w = {ref_bytes[35], ref_bytes[34], ref_bytes[33], ref_bytes[32]};
        bus.req_wr = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h020;
        bus.req_wdata = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_eq("abort_we_before", bus.dm_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_we", bus.dm_we, 1'b0);
        check_eq("abort_ready", bus.req_ready, 1'b1);
        check_eq("abort_be", bus.dm_be, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_resp", bus.resp_valid, 1'b0);
        end
        rst_n = 1'b1;
        check_eq("abort_mem", mem[8], w);

        for (int t = 0; t < 250; t++) begin
            sz = 2'($urandom_range(0, 3));
            do_req(1'($urandom), sz, 1'($urandom),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom,
                   $urandom, r, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
